// File: rtl/dfio_pkg.sv
// Shared defaults, word type and pointer sizing helper for the dfio delay FIFO.
package dfio_pkg;

    localparam int DFIO_WIDTH_DEF = 32;
    localparam int DFIO_DEPTH_DEF = 8;

    typedef logic [DFIO_WIDTH_DEF-1:0] dfio_word_t;

    // Pointer needs at least one bit even when DEPTH is 1 or 2.
    function automatic int ptr_bits(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/dfio_wrap_ctr.sv
// Modulo-MODULUS up-counter with async active-low clear and increment enable.
module dfio_wrap_ctr
    import dfio_pkg::*;
#(
    parameter int MODULUS = DFIO_DEPTH_DEF,
    parameter int W       = ptr_bits(MODULUS)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Explicit compare-and-wrap so non-power-of-two moduli are exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc) begin
            if (count == W'(MODULUS - 1)) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dfio_delay_fifo.sv
// Enable-gated fixed-depth delay line: each enabled beat returns the word
// pushed DEPTH enabled beats earlier.
module dfio_delay_fifo
    import dfio_pkg::*;
#(
    parameter int WIDTH = DFIO_WIDTH_DEF,
    parameter int DEPTH = DFIO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int PW = ptr_bits(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;

    dfio_wrap_ctr #(
        .MODULUS (DEPTH),
        .W       (PW)
    ) u_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (enable),
        .count (ptr)
    );

    // Read old entry and overwrite it on the same edge; no bypass path,
    // so DEPTH=1 still yields the previous beat's word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (enable) begin
            dout     <= mem[ptr];
            mem[ptr] <= din;
        end
    end

endmodule

// File: tb/tb_dfio_delay_fifo.sv
// Bench for dfio_delay_fifo at DEPTH 8, 5 and 1 driven from shared stimulus.
module tb_dfio_delay_fifo;
    import dfio_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    dfio_word_t din;
    dfio_word_t dout8, dout5, dout1;

    int checks = 0;
    int fails  = 0;
    logic x_seen = 1'b0;

    // Reference model: one queue per depth holding exactly DEPTH words.
    dfio_word_t q8[$], q5[$], q1[$];
    dfio_word_t e8, e5, e1;

    typedef struct {
        logic       en;
        dfio_word_t din;
        dfio_word_t e8;
        dfio_word_t e5;
        dfio_word_t e1;
    } vec_t;
    vec_t tbl[16];

    always #5 clk = ~clk;

    dfio_delay_fifo #(.WIDTH(32), .DEPTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .din(din), .dout(dout8));
    dfio_delay_fifo #(.WIDTH(32), .DEPTH(5)) u5 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .din(din), .dout(dout5));
    dfio_delay_fifo #(.WIDTH(32), .DEPTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .din(din), .dout(dout1));

    always @(posedge clk) begin
        if (rst_n === 1'b1 && $isunknown(enable)) x_seen <= 1'b1;
    end

    task automatic chk(input string name, input dfio_word_t act, input dfio_word_t exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q8.delete(); q5.delete(); q1.delete();
        for (int i = 0; i < 8; i++) q8.push_back('0);
        for (int i = 0; i < 5; i++) q5.push_back('0);
        q1.push_back('0);
        e8 = '0; e5 = '0; e1 = '0;
    endtask

    task automatic step(input logic en, input dfio_word_t d);
        @(negedge clk);
        enable = en;
        din    = d;
        @(posedge clk);
        #1;
        if (en) begin
            e8 = q8.pop_front(); q8.push_back(d);
            e5 = q5.pop_front(); q5.push_back(d);
            e1 = q1.pop_front(); q1.push_back(d);
        end
        chk("model_d8", dout8, e8);
        chk("model_d5", dout5, e5);
        chk("model_d1", dout1, e1);
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        din    = '0;
        model_reset();

        // Fill-and-drain table: din = 1..16 on consecutive beats from empty.
        for (int i = 0; i < 16; i++) begin
            tbl[i].en  = 1'b1;
            tbl[i].din = dfio_word_t'(i + 1);
            tbl[i].e8  = (i < 8) ? '0 : dfio_word_t'(i - 7);
            tbl[i].e5  = (i < 5) ? '0 : dfio_word_t'(i - 4);
            tbl[i].e1  = dfio_word_t'(i);
        end

        // Reset held for 100 ns.
        #1;  chk("rst_d8", dout8, '0); chk("rst_d5", dout5, '0); chk("rst_d1", dout1, '0);
        #50; chk("rst_d8", dout8, '0); chk("rst_d5", dout5, '0); chk("rst_d1", dout1, '0);
        #49;
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) step(1'b0, dfio_word_t'($urandom));

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].en, tbl[i].din);
            chk("tbl_d8", dout8, tbl[i].e8);
            chk("tbl_d5", dout5, tbl[i].e5);
            chk("tbl_d1", dout1, tbl[i].e1);
        end

        // Gapped enable: one beat every third cycle.
        for (int k = 0; k < 16; k++) begin
            step(1'b1, dfio_word_t'(32'hA0 + k));
            if (k == 8) chk("gap_9th_d8", dout8, 32'h0000_00A0);
            step(1'b0, dfio_word_t'($urandom));
            step(1'b0, dfio_word_t'($urandom));
        end

        // Async reset pulse between edges after five pushes.
        for (int k = 0; k < 5; k++) step(1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        enable = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_d8", dout8, '0); chk("arst_d5", dout5, '0); chk("arst_d1", dout1, '0);
        #2 rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 8; k++) begin
            step(1'b1, dfio_word_t'(32'h5000 + k));
            chk("post_rst_zero_d8", dout8, '0);
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b1, dfio_word_t'(32'h6000 + k));
            chk("post_rst_data_d8", dout8, dfio_word_t'(32'h5000 + k));
        end

        // Continuous 0..19 for DEPTH=5 wrap.
        for (int n = 0; n < 20; n++) begin
            step(1'b1, dfio_word_t'(n));
            if (n >= 5) chk("wrap_d5", dout5, dfio_word_t'(n - 5));
        end

        // Randomized enable and data against the model.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 9) < 6), dfio_word_t'($urandom));
        end

        chk("enable_known", dfio_word_t'(x_seen), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
